trig_sequencer: RTL and testbench

//   Front-end controller for the trig LUT datapath (cosine/tangent LUT, 64-bit DFPU output).

---
 rtl/trig_sequencer.sv | 155 +++++++++++++++
 tb/tb_trig_sequencer.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/trig_sequencer.sv
// trig_sequencer: front-end controller for the trig LUT datapath.
// Takes one sin/cos/tan request with an integer angle in degrees, folds the
// angle into 0..90, issues a single LUT lookup, applies the quadrant sign to
// the returned magnitude and hands the result out on a valid/ready port.
module trig_sequencer #(
  parameter int DATA_WIDTH  = 16,
  parameter int LUT_LATENCY = 1    // 1..7
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [1:0]            req_func,
  input  logic [DATA_WIDTH-1:0] req_angle,
  output logic                  lut_en,
  output logic                  lut_en_tangent,
  output logic [DATA_WIDTH-1:0] lut_angle,
  input  logic [63:0]           lut_data,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [63:0]           res_data,
  output logic                  res_err
);

  typedef enum logic [2:0] {S_IDLE, S_REDUCE, S_ISSUE, S_WAIT, S_OUTPUT} state_t;

  localparam logic [DATA_WIDTH-1:0] D90  = DATA_WIDTH'(90);
  localparam logic [DATA_WIDTH-1:0] D180 = DATA_WIDTH'(180);
  localparam logic [DATA_WIDTH-1:0] D270 = DATA_WIDTH'(270);
  localparam logic [DATA_WIDTH-1:0] D360 = DATA_WIDTH'(360);
  localparam logic [2:0]            LAT3 = 3'(LUT_LATENCY);
  localparam logic [63:0]           NAN  = 64'h7FF8000000000000;
  localparam logic [63:0]           PINF = 64'h7FF0000000000000;

  state_t                r_state, w_state_nxt;
  logic [1:0]            r_func;
  logic [DATA_WIDTH-1:0] r_angle;
  logic [1:0]            r_q;
  logic [DATA_WIDTH-1:0] r_lut_angle;
  logic [2:0]            r_cnt;
  logic [63:0]           r_res;
  logic                  r_err;

  logic [1:0]            w_q;
  logic [DATA_WIDTH-1:0] w_ref;
  logic                  w_nan, w_inf, w_neg;

  // Angle reduction: quadrant, reference angle and error classification.
  // Out-of-range angles land in the last branch but are overridden by w_nan.
  always_comb begin
    w_q   = 2'd0;
    w_ref = r_angle;
    if (r_angle <= D90) begin
      w_q   = 2'd0;
      w_ref = r_angle;
    end else if (r_angle <= D180) begin
      w_q   = 2'd1;
      w_ref = D180 - r_angle;
    end else if (r_angle <= D270) begin
      w_q   = 2'd2;
      w_ref = r_angle - D180;
    end else begin
      w_q   = 2'd3;
      w_ref = D360 - r_angle;
    end
    w_nan = (r_angle >= D360) || (r_func == 2'b11);
    w_inf = (r_func == 2'b10) && ((r_angle == D90) || (r_angle == D270));
  end

  // Quadrant sign: sin negative in q2/q3, cos in q1/q2, tan in q1/q3.
  always_comb begin
    case (r_func)
      2'b00:   w_neg = r_q[1];
      2'b01:   w_neg = r_q[1] ^ r_q[0];
      2'b10:   w_neg = r_q[0];
      default: w_neg = 1'b0;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  // Next state and outputs; all outputs are quiet outside their owning state.
  always_comb begin
    w_state_nxt    = r_state;
    req_ready      = 1'b0;
    lut_en         = 1'b0;
    lut_en_tangent = 1'b0;
    lut_angle      = '0;
    res_valid      = 1'b0;
    res_data       = '0;
    res_err        = 1'b0;
    case (r_state)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) w_state_nxt = S_REDUCE;
      end
      S_REDUCE: w_state_nxt = (w_nan || w_inf) ? S_OUTPUT : S_ISSUE;
      S_ISSUE: begin
        lut_en         = 1'b1;
        lut_en_tangent = (r_func == 2'b10);
        lut_angle      = r_lut_angle;
        w_state_nxt    = S_WAIT;
      end
      S_WAIT: if (r_cnt == 3'd1) w_state_nxt = S_OUTPUT;
      S_OUTPUT: begin
        res_valid = 1'b1;
        res_data  = r_res;
        res_err   = r_err;
        if (res_ready) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Datapath: request capture, reduction results, latency counter, result.
  // The sign bit is cleared for a zero magnitude so -0 is never produced.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_func      <= '0;
      r_angle     <= '0;
      r_q         <= '0;
      r_lut_angle <= '0;
      r_cnt       <= '0;
      r_res       <= '0;
      r_err       <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (req_valid) begin
          r_func  <= req_func;
          r_angle <= req_angle;
        end
        S_REDUCE: begin
          r_q         <= w_q;
          r_lut_angle <= (r_func == 2'b00) ? D90 - w_ref : w_ref;
          r_err       <= w_nan | w_inf;
          r_res       <= w_nan ? NAN : (w_inf ? PINF : 64'd0);
        end
        S_ISSUE: r_cnt <= LAT3;
        S_WAIT: begin
          r_cnt <= r_cnt - 3'd1;
          if (r_cnt == 3'd1) begin
            r_res <= {w_neg & (|lut_data[62:0]), lut_data[62:0]};
            r_err <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_trig_sequencer.sv
// Directed bench for trig_sequencer with a behavioural LUT and a result
// scoreboard: expectations are queued when a request is sent and compared
// when the result handshake appears.
module tb_trig_sequencer;
  localparam int LAT = 1;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [1:0]  req_func = 2'b00;
  logic [15:0] req_angle = 16'd0;
  logic        lut_en, lut_en_tangent;
  logic [15:0] lut_angle;
  logic [63:0] lut_data;
  logic        res_valid;
  logic        res_ready = 1'b0;
  logic [63:0] res_data;
  logic        res_err;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [63:0] d;
    logic        e;
    logic [15:0] la;
    logic        t;
  } exp_t;
  exp_t sb[$];

  trig_sequencer #(.DATA_WIDTH(16), .LUT_LATENCY(LAT)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_func(req_func), .req_angle(req_angle),
    .lut_en(lut_en), .lut_en_tangent(lut_en_tangent), .lut_angle(lut_angle),
    .lut_data(lut_data),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_err(res_err)
  );

  always #5 clk = ~clk;

  // Behavioural LUT: known points exact, others a synthetic pattern with the
  // sign bit set so the sequencer's sign override is exercised.
  function automatic logic [63:0] lut_model(input logic [15:0] ang, input logic tn);
    if (tn) begin
      if (ang == 16'd0)  return 64'h0;
      if (ang == 16'd45) return 64'h3FF0000000000000;
      return {1'b1, 11'h400, 36'h0, ang};
    end
    if (ang == 16'd0)  return 64'h3FF0000000000000;
    if (ang == 16'd60) return 64'h3FE0000000000000;
    if (ang == 16'd90) return 64'h0;
    return {1'b1, 11'h3FD, 36'h0, ang};
  endfunction

  logic [63:0] lpipe [LAT];
  always @(posedge clk) begin
    if (lut_en) lpipe[0] <= lut_model(lut_angle, lut_en_tangent);
    for (int k = 1; k < LAT; k++) lpipe[k] <= lpipe[k-1];
  end
  assign lut_data = lpipe[LAT-1];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Present a request at a negedge and return at the negedge of cycle A+1.
  task automatic send(input logic [1:0] f, input logic [15:0] a, input logic [63:0] ed,
                      input logic ee, input logic [15:0] ela, input logic et);
    exp_t x;
    int w;
    x.d = ed; x.e = ee; x.la = ela; x.t = et;
    sb.push_back(x);
    req_func = f; req_angle = a; req_valid = 1'b1;
    w = 0;
    while (!req_ready && w < 50) begin @(negedge clk); w++; end
    chk("accept_timeout", 64'(w < 50), 64'd1);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  // Watch from A+1 until the result, compare against the scoreboard, then
  // optionally stall the consumer (with a pending request) before accepting.
  task automatic collect(input int hold, input logic pend,
                         input logic [1:0] pf, input logic [15:0] pa);
    exp_t x;
    int cyc, nlut, lcyc;
    logic [15:0] la;
    logic lt;
    cyc = 1; nlut = 0; lcyc = -1; la = '0; lt = 1'b0;
    while (!res_valid && cyc < 40) begin
      if (lut_en) begin nlut++; lcyc = cyc; la = lut_angle; lt = lut_en_tangent; end
      @(negedge clk);
      cyc++;
    end
    chk("res_timeout", 64'(res_valid), 64'd1);
    if (sb.size() == 0) begin
      chk("sb_empty", 64'(sb.size()), 64'd1);
      return;
    end
    x = sb.pop_front();
    chk("res_data", res_data, x.d);
    chk("res_err", 64'(res_err), 64'(x.e));
    chk("res_latency", 64'(cyc), x.e ? 64'd2 : 64'(3 + LAT));
    chk("lut_en_count", 64'(nlut), x.e ? 64'd0 : 64'd1);
    if (!x.e) begin
      chk("lut_en_cycle", 64'(lcyc), 64'd2);
      chk("lut_angle", 64'(la), 64'(x.la));
      chk("lut_tangent", 64'(lt), 64'(x.t));
    end
    for (int i = 0; i < hold; i++) begin
      if (pend) begin req_func = pf; req_angle = pa; req_valid = 1'b1; end
      @(negedge clk);
      chk("hold_valid", 64'(res_valid), 64'd1);
      chk("hold_data", res_data, x.d);
      chk("hold_req_ready", 64'(req_ready), 64'd0);
    end
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    chk("post_hs_valid", 64'(res_valid), 64'd0);
    chk("post_hs_req_ready", 64'(req_ready), 64'd1);
  endtask

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_req_ready", 64'(req_ready), 64'd1);
    chk("rst_lut_en", 64'(lut_en), 64'd0);
    chk("rst_res_valid", 64'(res_valid), 64'd0);
    chk("rst_res_data", res_data, 64'd0);
    chk("rst_res_err", 64'(res_err), 64'd0);
    reset_n = 1'b1;
    @(negedge clk);

    // Main function across quadrants and functions
    send(2'b01, 16'd0,   64'h3FF0000000000000, 1'b0, 16'd0,  1'b0); collect(0, 1'b0, 2'b00, 16'd0);
    send(2'b00, 16'd30,  64'h3FE0000000000000, 1'b0, 16'd60, 1'b0); collect(0, 1'b0, 2'b00, 16'd0);
    send(2'b01, 16'd120, 64'hBFE0000000000000, 1'b0, 16'd60, 1'b0); collect(0, 1'b0, 2'b00, 16'd0);
    send(2'b10, 16'd135, 64'hBFF0000000000000, 1'b0, 16'd45, 1'b1); collect(0, 1'b0, 2'b00, 16'd0);
    send(2'b00, 16'd180, 64'h0000000000000000, 1'b0, 16'd90, 1'b0); collect(0, 1'b0, 2'b00, 16'd0);
    send(2'b10, 16'd225, 64'h3FF0000000000000, 1'b0, 16'd45, 1'b1); collect(0, 1'b0, 2'b00, 16'd0);
    send(2'b10, 16'd315, 64'hBFF0000000000000, 1'b0, 16'd45, 1'b1); collect(0, 1'b0, 2'b00, 16'd0);
    send(2'b01, 16'd90,  64'h0000000000000000, 1'b0, 16'd90, 1'b0); collect(0, 1'b0, 2'b00, 16'd0);
    send(2'b01, 16'd359, {1'b0, 11'h3FD, 36'h0, 16'd1}, 1'b0, 16'd1, 1'b0); collect(0, 1'b0, 2'b00, 16'd0);

    // Error paths
    send(2'b10, 16'd90,  64'h7FF0000000000000, 1'b1, 16'd0, 1'b0); collect(0, 1'b0, 2'b00, 16'd0);
    send(2'b10, 16'd270, 64'h7FF0000000000000, 1'b1, 16'd0, 1'b0); collect(0, 1'b0, 2'b00, 16'd0);
    send(2'b00, 16'd400, 64'h7FF8000000000000, 1'b1, 16'd0, 1'b0); collect(0, 1'b0, 2'b00, 16'd0);
    send(2'b00, 16'd360, 64'h7FF8000000000000, 1'b1, 16'd0, 1'b0); collect(0, 1'b0, 2'b00, 16'd0);
    send(2'b11, 16'd45,  64'h7FF8000000000000, 1'b1, 16'd0, 1'b0); collect(0, 1'b0, 2'b00, 16'd0);

    // Back-pressure with a queued request waiting for IDLE
    send(2'b00, 16'd210, 64'hBFE0000000000000, 1'b0, 16'd60, 1'b0); collect(5, 1'b1, 2'b01, 16'd300);
    send(2'b01, 16'd300, 64'h3FE0000000000000, 1'b0, 16'd60, 1'b0); collect(0, 1'b0, 2'b00, 16'd0);

    // Reset while waiting on the LUT
    send(2'b01, 16'd0, 64'h3FF0000000000000, 1'b0, 16'd0, 1'b0);
    @(negedge clk);
    chk("mid_lut_en", 64'(lut_en), 64'd1);
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    chk("mrst_req_ready", 64'(req_ready), 64'd1);
    chk("mrst_lut_en", 64'(lut_en), 64'd0);
    chk("mrst_res_valid", 64'(res_valid), 64'd0);
    chk("mrst_res_data", res_data, 64'd0);
    chk("mrst_res_err", 64'(res_err), 64'd0);
    sb.delete();
    reset_n = 1'b1;
    @(negedge clk);
    chk("mrst_no_result", 64'(res_valid), 64'd0);
    send(2'b00, 16'd150, 64'h3FE0000000000000, 1'b0, 16'd60, 1'b0); collect(0, 1'b0, 2'b00, 16'd0);

    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
